// File: rtl/sd_cmd_responder_if.sv
// CMD line and card-logic handshake signals of the SD card-side command responder.
// Optional input crc_inj_i exists only when SD_CMD_RSP_CRC_INJECT_EN is defined.
interface sd_cmd_responder_if;
  logic         cmd_i;
  logic         cmd_o;
  logic         cmd_oe_o;
  logic         cmd_valid_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         crc_err_o;
  logic         rsp_ready_o;
  logic         rsp_valid_i;
  logic         rsp_long_i;
  logic [127:0] rsp_data_i;
  logic         busy_o;
`ifdef SD_CMD_RSP_CRC_INJECT_EN
  logic         crc_inj_i;
`endif

  modport slave (
    input  cmd_i, rsp_valid_i, rsp_long_i, rsp_data_i,
    output cmd_o, cmd_oe_o, cmd_valid_o, cmd_index_o, cmd_arg_o,
           crc_err_o, rsp_ready_o, busy_o
`ifdef SD_CMD_RSP_CRC_INJECT_EN
    , input crc_inj_i
`endif
  );

  modport master (
    output cmd_i, rsp_valid_i, rsp_long_i, rsp_data_i,
    input  cmd_o, cmd_oe_o, cmd_valid_o, cmd_index_o, cmd_arg_o,
           crc_err_o, rsp_ready_o, busy_o
`ifdef SD_CMD_RSP_CRC_INJECT_EN
    , output crc_inj_i
`endif
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit commands (CRC7 checked), serialises R1/R3/R6/R7 or R2 responses.
// Define SD_CMD_RSP_CRC_INJECT_EN to add crc_inj_i, which corrupts CRC7 bit0 of the accepted response.
module sd_cmd_responder #(
  parameter int NCR     = 2,
  parameter int RSP_TMO = 64
) (
  input  logic                  clksd,
  input  logic                  rst_n,
  sd_cmd_responder_if.slave     bus,
  output logic [2:0]            dbg_state
);

  // Handshake: a response is accepted on the rising edge where rsp_valid_i and rsp_ready_o are both high;
  // rsp_ready_o is high only in S_WAIT_RSP, so rsp_valid_i is ignored everywhere else.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX       = 3'd1,
    S_CHECK    = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_NCR      = 3'd4,
    S_TX       = 3'd5
  } state_t;

  state_t         state, state_next;
  logic [7:0]     cnt;
  logic [47:0]    rx_sr;
  logic [135:0]   tx_sr;
  logic           tx_long;
  logic [6:0]     rx_crc;
  logic           frame_ok;
  logic           rsp_accept;
  logic           tx_last;
  logic           inj_bit;
  logic [6:0]     rsp_crc;
  logic [135:0]   rsp_frame;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  always_comb begin
    rx_crc   = crc7_40(rx_sr[47:8]);
    frame_ok = ~rx_sr[47] & rx_sr[46] & rx_sr[0] & (rx_crc == rx_sr[7:1]);
  end

  assign rsp_accept = (state == S_WAIT_RSP) & bus.rsp_valid_i;
  assign tx_last    = tx_long ? (cnt == 8'd135) : (cnt == 8'd47);

`ifdef SD_CMD_RSP_CRC_INJECT_EN
  assign inj_bit = bus.crc_inj_i;
`else
  assign inj_bit = 1'b0;
`endif

  // Both response shapes are left-aligned in tx_sr so TX always shifts out of bit 135.
  always_comb begin
    rsp_crc   = 7'd0;
    rsp_frame = '0;
    if (bus.rsp_long_i) begin
      rsp_crc   = crc7_120(bus.rsp_data_i[127:8]) ^ {6'd0, inj_bit};
      rsp_frame = {2'b00, 6'b111111, bus.rsp_data_i[127:8], rsp_crc, 1'b1};
    end else begin
      rsp_crc   = crc7_40({2'b00, bus.rsp_data_i[37:0]}) ^ {6'd0, inj_bit};
      rsp_frame = {2'b00, bus.rsp_data_i[37:0], rsp_crc, 1'b1, 88'd0};
    end
  end

  always_ff @(posedge clksd) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (!bus.cmd_i) state_next = S_RX;
      S_RX:       if (cnt == 8'd46) state_next = S_CHECK;
      S_CHECK:    state_next = frame_ok ? S_WAIT_RSP : S_IDLE;
      S_WAIT_RSP: begin
        if (rsp_accept)                    state_next = S_NCR;
        else if (cnt == 8'(RSP_TMO - 1))   state_next = S_IDLE;
      end
      S_NCR:      if (cnt == 8'(NCR - 1)) state_next = S_TX;
      S_TX:       if (tx_last) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign bus.cmd_oe_o    = (state == S_TX);
  assign bus.cmd_o       = (state == S_TX) ? tx_sr[135] : 1'b1;
  assign bus.rsp_ready_o = (state == S_WAIT_RSP);
  assign bus.busy_o      = (state != S_IDLE);
  assign dbg_state       = state;

  // One counter serves every timed state; it restarts from zero on each state change.
  always_ff @(posedge clksd) begin
    if (!rst_n) begin
      cnt             <= 8'd0;
      rx_sr           <= 48'd0;
      tx_sr           <= '1;
      tx_long         <= 1'b0;
      bus.cmd_valid_o <= 1'b0;
      bus.crc_err_o   <= 1'b0;
      bus.cmd_index_o <= 6'd0;
      bus.cmd_arg_o   <= 32'd0;
    end else begin
      bus.cmd_valid_o <= 1'b0;
      bus.crc_err_o   <= 1'b0;
      cnt             <= (state_next != state) ? 8'd0 : cnt + 8'd1;
      case (state)
        S_IDLE: rx_sr <= 48'd0;
        S_RX:   rx_sr <= {rx_sr[46:0], bus.cmd_i};
        S_CHECK: begin
          if (frame_ok) begin
            bus.cmd_valid_o <= 1'b1;
            bus.cmd_index_o <= rx_sr[45:40];
            bus.cmd_arg_o   <= rx_sr[39:8];
          end else begin
            bus.crc_err_o   <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_accept) begin
            tx_sr   <= rsp_frame;
            tx_long <= bus.rsp_long_i;
          end
        end
        S_TX:    tx_sr <= {tx_sr[134:0], 1'b1};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: random host commands and card responses against a CRC7 long-division model.
module tb_sd_cmd_responder;
  localparam int NCR     = 2;
  localparam int RSP_TMO = 64;
  localparam int PERIOD  = 10;

  logic       clksd = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  sd_cmd_responder_if bus();

  sd_cmd_responder #(.NCR(NCR), .RSP_TMO(RSP_TMO)) dut (
    .clksd     (clksd),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #(PERIOD / 2) clksd = ~clksd;

  int           checks   = 0;
  int           failures = 0;
  logic [38:0]  cmd_exp_q[$];
  logic [135:0] rsp_exp_q[$];
  int           rsp_len_q[$];
  logic [5:0]   last_idx  = 6'd0;
  logic [31:0]  last_arg  = 32'd0;
  time          acc_time  = 0;
  logic         abort_rsp = 1'b0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1, by long division over a bit array.
  function automatic logic [6:0] ref_crc(input logic [127:0] m, input int n);
    logic       arr [0:134];
    logic [7:0] g;
    logic [6:0] r;
    g = 8'h89;
    for (int i = 0; i < 135; i++) arr[i] = 1'b0;
    for (int i = 0; i < n; i++) arr[i] = m[n-1-i];
    for (int i = 0; i < n; i++)
      if (arr[i])
        for (int j = 0; j < 8; j++) arr[i+j] = arr[i+j] ^ g[7-j];
    for (int k = 0; k < 7; k++) r[6-k] = arr[n+k];
    return r;
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] c;
    c = ref_crc({88'd0, 2'b01, idx, arg}, 40);
    return {2'b01, idx, arg, c, 1'b1};
  endfunction

  function automatic logic [135:0] model_rsp(input logic lng, input logic [127:0] d,
                                            input logic inj, output int len);
    logic [6:0] c;
    if (lng) begin
      c   = ref_crc({8'd0, d[127:8]}, 120) ^ {6'd0, inj};
      len = 136;
      return {2'b00, 6'h3f, d[127:8], c, 1'b1};
    end else begin
      c   = ref_crc({88'd0, 2'b00, d[37:0]}, 40) ^ {6'd0, inj};
      len = 48;
      return {88'd0, 2'b00, d[37:0], c, 1'b1};
    end
  endfunction

  // Command-event monitor: every cmd_valid_o / crc_err_o pulse consumes one expectation.
  always @(negedge clksd) begin
    if (rst_n && (bus.cmd_valid_o || bus.crc_err_o)) begin
      if (cmd_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected actual=%0b%0b expected=none", bus.cmd_valid_o, bus.crc_err_o);
      end else begin
        logic [38:0] e;
        e = cmd_exp_q.pop_front();
        check("cmd_event", {96'd0, bus.cmd_valid_o, bus.crc_err_o, bus.cmd_index_o, bus.cmd_arg_o},
              {96'd0, e[38], ~e[38], e[37:0]});
      end
    end
  end

  // Response monitor: captures each driven frame and compares it on the falling edge of cmd_oe_o.
  logic         prev_oe = 1'b0;
  logic [135:0] cap     = '0;
  int           cap_n   = 0;
  always @(negedge clksd) begin
    if (bus.cmd_oe_o) begin
      if (!prev_oe) begin
        cap   = '0;
        cap_n = 0;
        check_int("rsp_ncr_start", int'(($time - acc_time) / PERIOD), NCR + 1);
      end
      cap = {cap[134:0], bus.cmd_o};
      cap_n++;
    end else if (prev_oe) begin
      if (abort_rsp) begin
        if (rsp_exp_q.size() != 0) begin
          void'(rsp_exp_q.pop_front());
          void'(rsp_len_q.pop_front());
        end
        abort_rsp = 1'b0;
      end else if (rsp_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected actual=%0h expected=none", cap);
      end else begin
        logic [135:0] e;
        int           l;
        e = rsp_exp_q.pop_front();
        l = rsp_len_q.pop_front();
        check_int("rsp_len", cap_n, l);
        check("rsp_frame", cap, e);
        check("rsp_line_release", {135'd0, bus.cmd_o}, 136'd1);
      end
    end
    prev_oe = bus.cmd_oe_o;
  end

  // Caller is at a negedge with the DUT idle; the first bit is driven immediately.
  task automatic send_raw(input logic [47:0] f, input logic good);
    if (good) begin
      cmd_exp_q.push_back({1'b1, f[45:40], f[39:8]});
      last_idx = f[45:40];
      last_arg = f[39:8];
    end else begin
      cmd_exp_q.push_back({1'b0, last_idx, last_arg});
    end
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_i = f[i];
      @(negedge clksd);
    end
    bus.cmd_i = 1'b1;
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input int kind);
    logic [47:0] f;
    f = cmd_frame(idx, arg);
    case (kind)
      1: f[3]  = ~f[3];
      2: f[46] = 1'b0;
      3: f[0]  = 1'b0;
      default: ;
    endcase
    send_raw(f, kind == 0);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (bus.busy_o && n < bound) begin
      @(negedge clksd);
      n++;
    end
    check(name, {135'd0, bus.busy_o}, 136'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.rsp_ready_o && n < 20) begin
      @(negedge clksd);
      n++;
    end
    check("rsp_ready_rise", {135'd0, bus.rsp_ready_o}, 136'd1);
  endtask

  task automatic no_rsp();
    int n;
    wait_ready();
    n = 0;
    while (bus.rsp_ready_o && n < RSP_TMO + 20) begin
      @(negedge clksd);
      n++;
    end
    check_int("rsp_timeout_len", n, RSP_TMO);
    check("rsp_timeout_idle", {135'd0, bus.busy_o}, 136'd0);
  endtask

  task automatic respond(input logic lng, input logic [127:0] d, input logic inj, input int delay,
                         input logic [135:0] lit, input int lit_len, input logic do_wait);
    logic [135:0] fr;
    int           len;
    wait_ready();
    repeat (delay) @(negedge clksd);
    if (lit_len != 0) begin
      fr  = lit;
      len = lit_len;
    end else begin
      fr = model_rsp(lng, d, inj, len);
    end
    rsp_exp_q.push_back(fr);
    rsp_len_q.push_back(len);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_long_i  = lng;
    bus.rsp_data_i  = d;
`ifdef SD_CMD_RSP_CRC_INJECT_EN
    bus.crc_inj_i   = inj;
`endif
    acc_time = $time;
    @(negedge clksd);
    bus.rsp_valid_i = 1'b0;
`ifdef SD_CMD_RSP_CRC_INJECT_EN
    bus.crc_inj_i   = 1'b0;
`endif
    if (do_wait) wait_idle(300, "rsp_done_idle");
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d;
    int           n;
    bus.cmd_i       = 1'b1;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_long_i  = 1'b0;
    bus.rsp_data_i  = '0;
`ifdef SD_CMD_RSP_CRC_INJECT_EN
    bus.crc_inj_i   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clksd);
    check("reset_outputs",
          {92'd0, bus.cmd_o, bus.cmd_oe_o, bus.cmd_valid_o, bus.crc_err_o, bus.rsp_ready_o,
           bus.busy_o, bus.cmd_index_o, bus.cmd_arg_o},
          {92'd0, 1'b1, 5'd0, 6'd0, 32'd0});
    rst_n = 1'b1;
    @(negedge clksd);

    // CMD0 with no response: drops back to idle after the timeout, line never driven
    send_raw(48'h40_0000_0000_95, 1'b1);
    no_rsp();

    // CMD8 with the known R7 response
    send_raw(48'h48_0000_01AA_87, 1'b1);
    respond(1'b0, {90'd0, 6'h08, 32'h0000_01AA}, 1'b0, 1, 136'h08_0000_01AA_13, 48, 1'b1);

    // CMD8 with a bad CRC byte: error pulse, held index/argument
    send_raw(48'h48_0000_01AA_85, 1'b0);
    wait_idle(10, "bad_crc_idle");
    check("bad_crc_hold", {98'd0, bus.cmd_index_o, bus.cmd_arg_o}, {98'd0, 6'd8, 32'h0000_01AA});

    // CMD2 with a long R2 response
    send_cmd(6'd2, 32'd0, 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    respond(1'b1, d, 1'b0, 3, '0, 0, 1'b1);

    // rsp_valid_i while idle has no effect
    bus.rsp_valid_i = 1'b1;
    repeat (5) @(negedge clksd);
    check("valid_outside_wait", {134'd0, bus.busy_o, bus.cmd_oe_o}, 136'd0);
    bus.rsp_valid_i = 1'b0;

    // Reset during TX bit 20
    send_cmd(6'd8, $urandom, 0);
    respond(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, '0, 0, 1'b0);
    n = 0;
    while (!bus.cmd_oe_o && n < 20) begin
      @(negedge clksd);
      n++;
    end
    repeat (20) @(negedge clksd);
    abort_rsp = 1'b1;
    rst_n     = 1'b0;
    @(negedge clksd);
    check("reset_mid_tx",
          {92'd0, bus.cmd_o, bus.cmd_oe_o, bus.busy_o, bus.rsp_ready_o, 2'b00,
           bus.cmd_index_o, bus.cmd_arg_o},
          {92'd0, 1'b1, 5'd0, 6'd0, 32'd0});
    rst_n    = 1'b1;
    last_idx = 6'd0;
    last_arg = 32'd0;
    @(negedge clksd);
    send_raw(48'h40_0000_0000_95, 1'b1);
    no_rsp();

`ifdef SD_CMD_RSP_CRC_INJECT_EN
    send_raw(48'h48_0000_01AA_87, 1'b1);
    respond(1'b0, {90'd0, 6'h08, 32'h0000_01AA}, 1'b1, 0, 136'h08_0000_01AA_11, 48, 1'b1);
    send_raw(48'h48_0000_01AA_87, 1'b1);
    respond(1'b0, {90'd0, 6'h08, 32'h0000_01AA}, 1'b0, 0, 136'h08_0000_01AA_13, 48, 1'b1);
`endif

    // Randomized traffic, including back-to-back starts on the first idle clock
    for (int t = 0; t < 14; t++) begin
      int sel;
      int kind;
      repeat ($urandom_range(0, 3)) @(negedge clksd);
      sel  = $urandom_range(0, 7);
      kind = (sel < 5) ? 0 : sel - 4;
      send_cmd(6'($urandom_range(0, 63)), $urandom, kind);
      if (kind != 0) begin
        wait_idle(10, "rand_bad_idle");
      end else if ($urandom_range(0, 3) == 0) begin
        no_rsp();
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        respond(1'($urandom_range(0, 1)), d, 1'b0, $urandom_range(0, RSP_TMO - 10), '0, 0, 1'b1);
      end
    end

    repeat (5) @(negedge clksd);
    check_int("cmd_queue_drained", cmd_exp_q.size(), 0);
    check_int("rsp_queue_drained", rsp_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
